// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Bundles the byte-stream handshake and the instruction-memory write port
//   seen by imem_loader.
//   Signals:
//     in_valid, in_data : byte stream from the program source
//     in_ready          : loader can take a byte this cycle
//     mem_we            : one-cycle write strobe per assembled word
//     mem_addr          : word address of the write
//     mem_wdata         : assembled word {high byte, low byte}
//   Modports:
//     master : environment side (drives the stream, observes the memory port)
//     slave  : loader side (accepts the stream, drives the memory port)
interface imem_loader_if #(
  parameter int ADDR_W = 4
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   Write-side companion of the risc16 instruction memory. Receives a program
//   image as a byte stream (length byte, then high/low byte pairs), writes
//   each 16-bit word to sequential addresses and keeps the CPU held in reset
//   until a complete, valid image has been loaded.
//   Ports:
//     clk          : system clock
//     rst_n        : asynchronous active-low reset
//     start        : one-cycle pulse that begins a new load (ignored while busy)
//     bus          : imem_loader_if.slave (byte stream in, memory write port out)
//     cpu_hold     : 1 = CPU held in reset
//     busy         : load in progress
//     done         : last load completed successfully
//     err          : last load aborted (sticky until the next accepted start)
//     words_loaded : words written by the current/last load
//   Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing
//   checksum byte equal to the XOR of all data bytes before releasing the CPU.
module imem_loader #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  imem_loader_if.slave      bus,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_HI,
    S_LO,
    S_WR,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        xor_q, xor_d;
`endif

  logic              in_ready;
  logic              xfer;
  logic [ADDR_W:0]   ptr_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      hi_q        <= '0;
      ptr_q       <= '0;
      count_q     <= '0;
      words_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      words_q     <= words_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q       <= xor_d;
`endif
    end
  end

  // Moore ready: purely a function of the state, never of in_valid.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_LEN, S_HI, S_LO: in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK:             in_ready = 1'b1;
`endif
      default:           in_ready = 1'b0;
    endcase
  end

  assign xfer    = bus.in_valid && in_ready;
  assign ptr_inc = {1'b0, ptr_q} + (ADDR_W+1)'(1);

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    words_d     = words_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_d       = xor_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_LEN;
          busy_d     = 1'b1;
          cpu_hold_d = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
          words_d    = '0;
          ptr_d      = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d      = '0;
`endif
        end
      end
      S_LEN: begin
        if (xfer) begin
          if (bus.in_data == 8'd0 || 32'(bus.in_data) > DEPTH) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            count_d = bus.in_data[ADDR_W:0];
            state_d = S_HI;
          end
        end
      end
      S_HI: begin
        if (xfer) begin
          hi_d    = bus.in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d   = xor_q ^ bus.in_data;
`endif
          state_d = S_LO;
        end
      end
      S_LO: begin
        // The write port registers are loaded here so the strobe is
        // visible during the WR cycle, one cycle after the low byte.
        if (xfer) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = ptr_q;
          mem_wdata_d = {hi_q, bus.in_data};
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d       = xor_q ^ bus.in_data;
`endif
          state_d     = S_WR;
        end
      end
      S_WR: begin
        ptr_d   = ptr_inc[ADDR_W-1:0];
        words_d = words_q + (ADDR_W+1)'(1);
        if (ptr_inc == count_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d    = S_CHK;
`else
          state_d    = S_DONE;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          cpu_hold_d = 1'b0;
`endif
        end else begin
          state_d = S_HI;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer) begin
          busy_d = 1'b0;
          if (bus.in_data == xor_q) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            // Written words stay in memory; the CPU simply stays held.
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_hold      = cpu_hold_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign words_loaded  = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Self-checking bench for imem_loader: a table of per-cycle vectors for the
//   basic load and length-error paths, then hand-written sequences for the
//   stalled full-depth load, reset mid-load and (when enabled) the checksum.
module tb_imem_loader;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              cpu_hold, busy, done, err;
  logic [ADDR_W:0]   words_loaded;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .bus          (bus.slave),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        st;
    logic        vld;
    logic [7:0]  d;
    logic        rdy;
    logic        we;
    logic [3:0]  addr;
    logic [15:0] wd;
    logic        hold;
    logic        bsy;
    logic        dn;
    logic        er;
    logic [4:0]  wl;
  } vec_t;

  vec_t vecs[$];

  // Writes seen on the memory port (one negedge sample per strobe).
  logic [3:0]  wr_addr[$];
  logic [15:0] wr_data[$];

  always @(negedge clk) begin
    if (rst_n && bus.mem_we) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [30:0] outs();
    return {bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata,
            cpu_hold, busy, done, err, words_loaded};
  endfunction

  task automatic add(input logic st, input logic vld, input logic [7:0] d,
                     input logic rdy, input logic we, input logic [3:0] addr,
                     input logic [15:0] wd, input logic hold, input logic bsy,
                     input logic dn, input logic er, input logic [4:0] wl);
    vec_t v;
    v.st = st; v.vld = vld; v.d = d; v.rdy = rdy; v.we = we; v.addr = addr;
    v.wd = wd; v.hold = hold; v.bsy = bsy; v.dn = dn; v.er = er; v.wl = wl;
    vecs.push_back(v);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_wait", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Assert reset part-way through a clock low phase and check the
  // asynchronous effect before any clock edge arrives.
  task automatic mid_clock_reset(input string name);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check(name, 64'(outs()), 64'({1'b0, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0}));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [7:0]  hi_b, lo_b, xsum;
  logic [30:0] exp_v;
  int          gap;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_state", 64'(outs()), 64'({1'b0, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0}));
    rst_n = 1'b1;

    // st vld data   rdy we addr wdata    hold busy done err wl
    add(1, 0, 8'h00, 1, 0, 4'd0, 16'h0000, 1, 1, 0, 0, 5'd0);  // -> LEN
    add(0, 1, 8'h02, 1, 0, 4'd0, 16'h0000, 1, 1, 0, 0, 5'd0);  // length 2 -> HI
    add(0, 1, 8'h12, 1, 0, 4'd0, 16'h0000, 1, 1, 0, 0, 5'd0);  // -> LO
    add(0, 1, 8'h34, 0, 1, 4'd0, 16'h1234, 1, 1, 0, 0, 5'd0);  // -> WR addr0
    add(0, 1, 8'hAB, 1, 0, 4'd0, 16'h1234, 1, 1, 0, 0, 5'd1);  // not ready: byte held
    add(0, 1, 8'hAB, 1, 0, 4'd0, 16'h1234, 1, 1, 0, 0, 5'd1);  // -> LO
    add(0, 1, 8'hCD, 0, 1, 4'd1, 16'hABCD, 1, 1, 0, 0, 5'd1);  // -> WR addr1
`ifdef IMEM_LOADER_CHECKSUM_EN
    add(0, 0, 8'h00, 1, 0, 4'd1, 16'hABCD, 1, 1, 0, 0, 5'd2);  // -> CHK
    add(0, 1, 8'h40, 0, 0, 4'd1, 16'hABCD, 0, 0, 1, 0, 5'd2);  // good sum -> DONE
`else
    add(0, 0, 8'h00, 0, 0, 4'd1, 16'hABCD, 0, 0, 1, 0, 5'd2);  // -> DONE
`endif
    add(0, 1, 8'h55, 0, 0, 4'd1, 16'hABCD, 0, 0, 1, 0, 5'd2);  // DONE ignores bytes
    add(1, 0, 8'h00, 1, 0, 4'd1, 16'hABCD, 1, 1, 0, 0, 5'd0);  // restart from DONE
    add(0, 0, 8'h00, 1, 0, 4'd1, 16'hABCD, 1, 1, 0, 0, 5'd0);  // gap, data ignored
    add(0, 1, 8'h00, 0, 0, 4'd1, 16'hABCD, 1, 0, 0, 1, 5'd0);  // L=0 -> err
    add(0, 1, 8'h05, 0, 0, 4'd1, 16'hABCD, 1, 0, 0, 1, 5'd0);  // err sticky in IDLE
    add(1, 0, 8'h00, 1, 0, 4'd1, 16'hABCD, 1, 1, 0, 0, 5'd0);  // start clears err
    add(1, 1, 8'h11, 0, 0, 4'd1, 16'hABCD, 1, 0, 0, 1, 5'd0);  // L=17 -> err
    add(1, 0, 8'h00, 1, 0, 4'd1, 16'hABCD, 1, 1, 0, 0, 5'd0);  // start
    add(0, 1, 8'h10, 1, 0, 4'd1, 16'hABCD, 1, 1, 0, 0, 5'd0);  // L=16 accepted -> HI
    add(1, 0, 8'h00, 1, 0, 4'd1, 16'hABCD, 1, 1, 0, 0, 5'd0);  // start ignored while busy

    foreach (vecs[i]) begin
      @(negedge clk);
      start        = vecs[i].st;
      bus.in_valid = vecs[i].vld;
      bus.in_data  = vecs[i].d;
      @(posedge clk);
      #1;
      exp_v = {vecs[i].rdy, vecs[i].we, vecs[i].addr, vecs[i].wd,
               vecs[i].hold, vecs[i].bsy, vecs[i].dn, vecs[i].er, vecs[i].wl};
      check($sformatf("vec%0d", i), 64'(outs()), 64'(exp_v));
      $display("vec %0d: start=%0b valid=%0b data=%02h -> outs=%08h", i,
               vecs[i].st, vecs[i].vld, vecs[i].d, outs());
    end
    start        = 1'b0;
    bus.in_valid = 1'b0;

    // Reset while a load is in progress.
    mid_clock_reset("reset_mid_load_busy");

    // Full-depth load with random stalls.
    wr_addr.delete();
    wr_data.delete();
    xsum = 8'h00;
    pulse_start();
    send_byte(8'h10);
    for (int i = 0; i < 16; i++) begin
      hi_b = 8'(8'h11 * i + 3);
      lo_b = 8'(8'hF0 - i);
      xsum = xsum ^ hi_b ^ lo_b;
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      send_byte(hi_b);
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      send_byte(lo_b);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(xsum);
`endif
    repeat (3) @(negedge clk);
    check("full_write_count", 64'(wr_addr.size()), 64'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < wr_addr.size()) begin
        check($sformatf("full_addr%0d", i), 64'(wr_addr[i]), 64'(i));
        check($sformatf("full_data%0d", i), 64'(wr_data[i]),
              64'({8'(8'h11 * i + 3), 8'(8'hF0 - i)}));
      end
    end
    check("full_status", 64'({cpu_hold, busy, done, err, words_loaded}),
          64'({1'b0, 1'b0, 1'b1, 1'b0, 5'd16}));
    $display("full-depth load: %0d writes, words_loaded=%0d", wr_addr.size(), words_loaded);

    // Reset after 3 of 5 bytes, then a fresh load.
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    mid_clock_reset("reset_mid_load_wr");
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    send_byte(8'h01);
    send_byte(8'hBE);
    send_byte(8'hEF);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h51);
`endif
    repeat (3) @(negedge clk);
    check("reload_write_count", 64'(wr_addr.size()), 64'd1);
    if (wr_addr.size() > 0)
      check("reload_write", 64'({wr_addr[0], wr_data[0]}), 64'({4'd0, 16'hBEEF}));
    check("reload_status", 64'({cpu_hold, busy, done, err, words_loaded}),
          64'({1'b0, 1'b0, 1'b1, 1'b0, 5'd1}));
    $display("reload after reset: %0d writes, done=%0b", wr_addr.size(), done);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h26);
    repeat (2) @(negedge clk);
    check("chk_good_status", 64'({cpu_hold, busy, done, err}), 64'({1'b0, 1'b0, 1'b1, 1'b0}));
    $display("checksum good: done=%0b cpu_hold=%0b", done, cpu_hold);

    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h00);
    repeat (2) @(negedge clk);
    check("chk_bad_write_count", 64'(wr_addr.size()), 64'd1);
    if (wr_addr.size() > 0)
      check("chk_bad_write", 64'({wr_addr[0], wr_data[0]}), 64'({4'd0, 16'h1234}));
    check("chk_bad_status", 64'({cpu_hold, busy, done, err}), 64'({1'b1, 1'b0, 1'b0, 1'b1}));
    $display("checksum bad: err=%0b cpu_hold=%0b", err, cpu_hold);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion of the risc16 instruction memory.
- Receives a program as a byte stream over a valid/ready handshake and assembles each pair of bytes into a 16-bit instruction.
- Writes each instruction through the memory's write port at sequential word addresses.
- Holds the CPU in reset (cpu_hold) until a complete, valid program image is loaded.

Parameters:
- ADDR_W, 4, word address width of the instruction memory.
- DEPTH, 16, maximum words per image; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse: begin a new load
- in_valid  input  1  byte stream valid
- in_data  input  8  byte stream data
- in_ready  output  1  loader can accept a byte this cycle
- mem_we  output  1  instruction memory write enable, one cycle per word
- mem_addr  output  ADDR_W  instruction memory word address
- mem_wdata  output  16  instruction word, {high byte, low byte}
- cpu_hold  output  1  1 = CPU held in reset
- busy  output  1  load in progress
- done  output  1  last load completed successfully
- err  output  1  last load aborted
- words_loaded  output  ADDR_W+1  words written in current/last load

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - cpu_hold=1; in_ready, mem_we, busy, done, err = 0.
  - mem_addr=0, mem_wdata=0, words_loaded=0.
  - Reset mid-load abandons the load. Memory words already written stay unspecified; the CPU stays held.
- Handshake:
  - A byte transfers only on a rising edge with in_valid=1 and in_ready=1.
  - in_ready is a Moore output of the state: 1 in LEN, HI, LO and CHK; 0 elsewhere.
  - in_data is ignored when no transfer occurs.
  - Arbitrary gaps in in_valid are legal.
- States:
  - IDLE: on start, go to LEN. Set busy=1 and cpu_hold=1; clear done, err and words_loaded; reset write pointer to 0.
  - LEN: accept the length byte L.
    - L==0 or L>DEPTH: err=1, busy=0, go to IDLE.
    - Otherwise store count=L and go to HI.
  - HI: accept a byte into hi_reg, go to LO.
  - LO: accept a byte into lo_reg, go to WR.
  - WR (single cycle):
    - mem_we=1, mem_addr=ptr, mem_wdata={hi_reg,lo_reg}; ptr and words_loaded increment.
    - If ptr+1==count, go to CHK (macro on) or DONE (macro off). Otherwise go to HI.
  - DONE: done=1, busy=0, cpu_hold=0. On start, behave as IDLE.start: re-enter LEN and re-assert cpu_hold.
- mem_addr, mem_wdata and mem_we are registered. Outside WR, mem_we=0 and mem_addr/mem_wdata hold their last values.
- Minimum throughput is 3 cycles per word (HI, LO, WR). Latency from the low-byte transfer to mem_we is 1 cycle.
- start is ignored while busy=1.
- ptr wraps naturally at DEPTH, but the length check guarantees it never needs to wrap.
- err stays set (sticky) until the next accepted start. cpu_hold remains 1 after an error.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WR, the state machine enters CHK and accepts one checksum byte.
  - The running XOR covers all data bytes (not the length byte) and is cleared on start.
  - Checksum byte equal to the running XOR: go to DONE.
  - Otherwise: err=1, busy=0, cpu_hold stays 1, done=0, go to IDLE. Words already written are not rolled back.
- Undefined: no CHK state and no XOR register; WR for the last word goes directly to DONE.

Test Plan:
- Reset check: assert rst_n=0 mid-clock, release -> cpu_hold=1, in_ready=0, mem_we=0, done=0, err=0, words_loaded=0.
- Basic load: start, then bytes 02,12,34,AB,CD back-to-back (macro off) -> mem_we pulses with (addr0,0x1234) then (addr1,0xABCD); then done=1, cpu_hold=0, busy=0, words_loaded=2.
- Bad length: start, byte 00 -> err=1, busy=0, no mem_we. Repeat with byte 11 (17) -> same result. A following start clears err.
- Stalls and full depth: start, length 0x10, then 32 bytes with random 0-3 cycle in_valid gaps -> exactly 16 mem_we pulses at addr 0..15 with correct data, words_loaded=16, no duplicate writes.
- Reset mid-load: after 3 of 5 bytes, pulse rst_n low -> all outputs return to reset values; a fresh start then loads correctly.
- Checksum (macro on): 01,12,34,26 -> done=1, cpu_hold=0. Then 01,12,34,00 -> mem_we at addr0 with 0x1234, then err=1, cpu_hold=1, done=0.
